// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: data width, NOP encoding,
// fetch FSM state encoding and the {pc, instr, pc_next} packet type.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_next;
    } fetch_pkt_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus interfaces of the fetch stage: the instruction-memory request/response
// bus and the decode-side valid/ready bus (with the redirect back-channel).

interface imem_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

interface decode_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output if_valid,
        output pc,
        output instruction,
        output pc_next,
        input  if_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  if_valid,
        input  pc,
        input  instruction,
        input  pc_next,
        output if_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched {pc, instr, pc_next} packet that
// arrives while the decode-facing output register is still occupied.
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       unload,
    input  logic       flush,
    input  fetch_pkt_t din,
    output logic       valid,
    output fetch_pkt_t dout
);

    logic       valid_q, valid_d;
    fetch_pkt_t data_q,  data_d;

    // Next-state: flush wins over load, load wins over unload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (unload) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '{pc: 32'h0, instr: 32'h0, pc_next: 32'h0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one word request at a time to instruction
// memory, presents {pc, instruction, pc_next} to decode and squashes stale
// fetches on a redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic     clk,
    input  logic     rst,
    imem_if.master   imem,
    decode_if.master dec
);
    import riscv_pkg::*;

    fetch_state_e state_q,     state_d;
    logic [31:0]  fetch_pc_q,  fetch_pc_d;
    logic         req_valid_q, req_valid_d;
    logic         out_valid_q, out_valid_d;
    fetch_pkt_t   out_q,       out_d;

    logic         req_hs;
    logic         resp;
    logic         consume;
    logic         redirect;
    logic         capture;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_flush;
    logic         skid_valid;
    logic         skid_valid_next;
    fetch_pkt_t   skid_dout;
    fetch_pkt_t   resp_pkt;

    assign req_hs   = req_valid_q & imem.imem_req_ready;
    assign resp     = imem.imem_resp_valid;
    assign consume  = out_valid_q & dec.if_ready;
    assign redirect = dec.redirect_valid;
    assign resp_pkt = '{pc: fetch_pc_q, instr: imem.imem_resp_data, pc_next: fetch_pc_q + 32'd4};

    fetch_skid_buffer u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .din    (resp_pkt),
        .valid  (skid_valid),
        .dout   (skid_dout)
    );

    // Fetch FSM next state and fetch PC; a redirect overrides every other event.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        capture    = 1'b0;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    state_d    = req_hs ? S_DROP : S_REQ;
                    fetch_pc_d = word_align(dec.redirect_pc);
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d    = resp ? S_REQ : S_DROP;
                    fetch_pc_d = word_align(dec.redirect_pc);
                end else if (resp) begin
                    state_d    = S_REQ;
                    capture    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                state_d = resp ? S_REQ : S_DROP;
                if (redirect) begin
                    fetch_pc_d = word_align(dec.redirect_pc);
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Output register / skid steering and request gating for the next cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        if (redirect) begin
            out_valid_d = 1'b0;
            out_d.instr = NOP_INSTR;
            skid_flush  = 1'b1;
        end else if (capture) begin
            if (!out_valid_q || consume) begin
                out_valid_d = 1'b1;
                out_d       = resp_pkt;
            end else begin
                skid_load = 1'b1;
            end
        end else if (consume) begin
            if (skid_valid) begin
                out_d       = skid_dout;
                skid_unload = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                out_d.instr = NOP_INSTR;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        skid_valid_next = skid_flush  ? 1'b0 :
                          skid_load   ? 1'b1 :
                          skid_unload ? 1'b0 : skid_valid;
        // A full skid blocks new requests so a third word is never in flight.
        req_valid_d = (state_d == S_REQ) && !skid_valid_next;
    end

    // State, PC and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= word_align(RESET_PC);
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '{pc: 32'h0, instr: NOP_INSTR, pc_next: 32'h0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = fetch_pc_q;
    assign dec.if_valid        = out_valid_q;
    assign dec.pc              = out_q.pc;
    assign dec.instruction     = out_q.instr;
    assign dec.pc_next         = out_q.pc_next;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory model answers each
// accepted request with addr ^ 32'hA5A5_0000, gated by mem_go.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    imem_if   imem_bus ();
    decode_if dec_bus ();

    logic        mem_pend;
    logic        mem_go;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .imem (imem_bus.master),
        .dec  (dec_bus.master)
    );

    // Memory model: one response per accepted request, held until mem_go.
    always @(posedge clk) begin
        if (rst) begin
            mem_pend <= 1'b0;
        end else if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
            mem_pend <= 1'b1;
            mem_addr <= imem_bus.imem_req_addr;
        end else if (imem_bus.imem_resp_valid) begin
            mem_pend <= 1'b0;
        end else begin
            mem_pend <= mem_pend;
        end
    end

    assign imem_bus.imem_resp_valid = mem_pend & mem_go;
    assign imem_bus.imem_resp_data  = mem_addr ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        mem_go = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        dec_bus.if_ready = 1'b1;
        dec_bus.redirect_valid = 1'b0;
        dec_bus.redirect_pc = 32'h0;

        // Reset state
        tick(2);
        chk("rst_if_valid", dec_bus.if_valid, 32'h0);
        chk("rst_req_valid", imem_bus.imem_req_valid, 32'h0);
        chk("rst_instr", dec_bus.instruction, 32'h0000_0013);
        chk("rst_pc", dec_bus.pc, 32'h0);
        chk("rst_pc_next", dec_bus.pc_next, 32'h0);
        rst = 1'b0;

        // 1: sequential fetch from 0x100
        tick(1);
        chk("t1_req_valid0", imem_bus.imem_req_valid, 32'h1);
        chk("t1_req_addr0", imem_bus.imem_req_addr, 32'h0000_0100);
        tick(1);
        chk("t1_req_wait", imem_bus.imem_req_valid, 32'h0);
        tick(1);
        chk("t1_valid0", dec_bus.if_valid, 32'h1);
        chk("t1_pc0", dec_bus.pc, 32'h0000_0100);
        chk("t1_instr0", dec_bus.instruction, 32'hA5A5_0100);
        chk("t1_pcn0", dec_bus.pc_next, 32'h0000_0104);
        chk("t1_req_addr1", imem_bus.imem_req_addr, 32'h0000_0104);
        tick(1);
        chk("t1_bubble_valid", dec_bus.if_valid, 32'h0);
        chk("t1_bubble_instr", dec_bus.instruction, 32'h0000_0013);
        tick(1);
        chk("t1_pc1", dec_bus.pc, 32'h0000_0104);
        chk("t1_pcn1", dec_bus.pc_next, 32'h0000_0108);
        chk("t1_req_addr2", imem_bus.imem_req_addr, 32'h0000_0108);

        // 2: decode stall fills the skid and blocks requests
        dec_bus.if_ready = 1'b0;
        tick(2);
        chk("t2_valid_a", dec_bus.if_valid, 32'h1);
        chk("t2_req_blocked_a", imem_bus.imem_req_valid, 32'h0);
        tick(4);
        chk("t2_valid_b", dec_bus.if_valid, 32'h1);
        chk("t2_pc_hold", dec_bus.pc, 32'h0000_0104);
        chk("t2_instr_hold", dec_bus.instruction, 32'hA5A5_0104);
        chk("t2_req_blocked_b", imem_bus.imem_req_valid, 32'h0);
        dec_bus.if_ready = 1'b1;
        tick(1);
        chk("t2_skid_pc", dec_bus.pc, 32'h0000_0108);
        chk("t2_skid_instr", dec_bus.instruction, 32'hA5A5_0108);
        chk("t2_skid_pcn", dec_bus.pc_next, 32'h0000_010C);
        chk("t2_req_resume", imem_bus.imem_req_valid, 32'h1);
        chk("t2_req_addr", imem_bus.imem_req_addr, 32'h0000_010C);

        // 3: redirect to 0x203 while waiting for a response
        mem_go = 1'b0;
        tick(1);
        chk("t3_waiting", imem_bus.imem_req_valid, 32'h0);
        dec_bus.redirect_valid = 1'b1;
        dec_bus.redirect_pc = 32'h0000_0203;
        tick(1);
        dec_bus.redirect_valid = 1'b0;
        mem_go = 1'b1;
        chk("t3_drop_valid", dec_bus.if_valid, 32'h0);
        chk("t3_drop_noreq", imem_bus.imem_req_valid, 32'h0);
        tick(1);
        chk("t3_stale_gone", dec_bus.if_valid, 32'h0);
        chk("t3_req_valid", imem_bus.imem_req_valid, 32'h1);
        chk("t3_req_addr", imem_bus.imem_req_addr, 32'h0000_0200);
        tick(2);
        chk("t3_pc", dec_bus.pc, 32'h0000_0200);
        chk("t3_instr", dec_bus.instruction, 32'hA5A5_0200);
        chk("t3_pcn", dec_bus.pc_next, 32'h0000_0204);

        // 4: redirect coincident with the response
        tick(1);
        dec_bus.redirect_valid = 1'b1;
        dec_bus.redirect_pc = 32'h0000_0200;
        tick(1);
        dec_bus.redirect_valid = 1'b0;
        chk("t4_no_stale", dec_bus.if_valid, 32'h0);
        chk("t4_nop", dec_bus.instruction, 32'h0000_0013);
        chk("t4_req_valid", imem_bus.imem_req_valid, 32'h1);
        chk("t4_req_addr", imem_bus.imem_req_addr, 32'h0000_0200);
        tick(1);
        chk("t4_still_empty", dec_bus.if_valid, 32'h0);
        tick(1);
        chk("t4_pc", dec_bus.pc, 32'h0000_0200);

        // 5: PC wrap at the top of the address space
        dec_bus.redirect_valid = 1'b1;
        dec_bus.redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        dec_bus.redirect_valid = 1'b0;
        chk("t5_flush", dec_bus.if_valid, 32'h0);
        tick(1);
        chk("t5_req_addr", imem_bus.imem_req_addr, 32'hFFFF_FFFC);
        tick(2);
        chk("t5_valid", dec_bus.if_valid, 32'h1);
        chk("t5_pc", dec_bus.pc, 32'hFFFF_FFFC);
        chk("t5_instr", dec_bus.instruction, 32'h5A5A_FFFC);
        chk("t5_pcn_wrap", dec_bus.pc_next, 32'h0000_0000);
        chk("t5_next_addr", imem_bus.imem_req_addr, 32'h0000_0000);
        chk("t5_next_valid", imem_bus.imem_req_valid, 32'h1);

        // 6: reset with the output register and skid both full
        dec_bus.if_ready = 1'b0;
        tick(2);
        chk("t6_pre_valid", dec_bus.if_valid, 32'h1);
        chk("t6_pre_blocked", imem_bus.imem_req_valid, 32'h0);
        rst = 1'b1;
        tick(1);
        chk("t6_if_valid", dec_bus.if_valid, 32'h0);
        chk("t6_req_valid", imem_bus.imem_req_valid, 32'h0);
        chk("t6_instr", dec_bus.instruction, 32'h0000_0013);
        chk("t6_pc", dec_bus.pc, 32'h0);
        rst = 1'b0;
        tick(1);
        chk("t6_restart_addr", imem_bus.imem_req_addr, 32'h0000_0100);
        chk("t6_restart_valid", imem_bus.imem_req_valid, 32'h1);
        tick(2);
        chk("t6_first_pc", dec_bus.pc, 32'h0000_0100);
        chk("t6_first_instr", dec_bus.instruction, 32'hA5A5_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
